// File: rtl/gesture_pkg.sv
// Shared types and constants for the hand-gesture frame pipeline.
package gesture_pkg;

  localparam int unsigned DEFAULT_IMAGE_WIDTH   = 384;
  localparam int unsigned DEFAULT_IMAGE_HEIGHT  = 216;
  localparam int unsigned FRAME_PIXELS          = DEFAULT_IMAGE_WIDTH * DEFAULT_IMAGE_HEIGHT;
  localparam int unsigned DEFAULT_PALM_TIMEOUT  = 4096;
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 4;

  localparam int unsigned THUMB  = 0;
  localparam int unsigned INDEX  = 1;
  localparam int unsigned MIDDLE = 2;
  localparam int unsigned RING   = 3;
  localparam int unsigned PINKY  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCapture,
    StWaitPalm,
    StScan,
    StSettle,
    StDone
  } state_e;

  function automatic logic [2:0] finger_popcount(input logic [4:0] mask);
    return 3'(mask[THUMB]) + 3'(mask[INDEX]) + 3'(mask[MIDDLE]) +
           3'(mask[RING]) + 3'(mask[PINKY]);
  endfunction

endpackage

// File: rtl/frame_raster_counter.sv
// Row/column raster counter over one frame; wraps to (0,0) after the last pixel.
module frame_raster_counter #(
  parameter int unsigned IMAGE_WIDTH  = 384,
  parameter int unsigned IMAGE_HEIGHT = 216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [8:0] row,
  output logic [8:0] col,
  output logic       last
);

  logic [8:0] row_q, row_d;
  logic [8:0] col_q, col_d;
  logic       col_end;

  assign col_end = (col_q == 9'(IMAGE_WIDTH - 1));
  assign last    = col_end && (row_q == 9'(IMAGE_HEIGHT - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      if (col_end) begin
        col_d = '0;
        row_d = last ? '0 : row_q + 9'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/gesture_frame_sequencer.sv
// Per-frame controller: clear, capture, palm wait, raster scan, settle, then
// hold the latched gesture result until downstream accepts it.
module gesture_frame_sequencer
  import gesture_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH   = DEFAULT_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT  = DEFAULT_IMAGE_HEIGHT,
  parameter int unsigned PALM_TIMEOUT  = DEFAULT_PALM_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic       palm_valid,
  input  logic [8:0] palm_width,
  input  logic [4:0] finger_status,
  output logic       capture_en,
  output logic       fid_rst,
  output logic       scan_flag,
  output logic [8:0] row_idx,
  output logic [8:0] col_idx,
  output logic       busy,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [4:0] finger_mask,
  output logic [2:0] finger_count,
  output logic       err_no_palm
);

  localparam int unsigned NumPix = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned ToW    = $clog2(PALM_TIMEOUT + 1);
  localparam int unsigned SetW   = $clog2(SETTLE_CYCLES + 1);

  state_e          state_q, state_d;
  logic [16:0]     pix_cnt_q, pix_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [SetW-1:0] settle_q, settle_d;

  logic       fid_rst_q, scan_flag_q, busy_q, result_valid_q, err_q;
  logic [4:0] mask_q;
  logic [2:0] count_q;

  logic       latch;
  logic       latch_err;
  logic [4:0] latch_mask;
  logic       raster_en, raster_clr, raster_last;

  frame_raster_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_raster (
    .clk   (clk),
    .rst   (rst),
    .clear (raster_clr),
    .enable(raster_en),
    .row   (row_idx),
    .col   (col_idx),
    .last  (raster_last)
  );

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = '0;
    to_cnt_d   = '0;
    settle_d   = '0;
    raster_en  = 1'b0;
    raster_clr = 1'b1;
    latch      = 1'b0;
    latch_err  = 1'b0;
    latch_mask = '0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        state_d = StCapture;
      end
      StCapture: begin
        pix_cnt_d = pix_cnt_q;
        if (pix_valid) begin
          if (pix_cnt_q == 17'(NumPix - 1)) begin
            state_d   = StWaitPalm;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 17'd1;
          end
        end
      end
      StWaitPalm: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        // A palm report in the timeout cycle still takes priority.
        if (palm_valid) begin
          if (palm_width != '0) begin
            state_d = StScan;
          end else begin
            state_d   = StDone;
            latch     = 1'b1;
            latch_err = 1'b1;
          end
        end else if (to_cnt_q == ToW'(PALM_TIMEOUT - 1)) begin
          state_d   = StDone;
          latch     = 1'b1;
          latch_err = 1'b1;
        end
      end
      StScan: begin
        raster_clr = 1'b0;
        raster_en  = 1'b1;
        if (raster_last) state_d = StSettle;
      end
      StSettle: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
          state_d    = StDone;
          latch      = 1'b1;
          latch_mask = finger_status;
        end
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pix_cnt_q      <= '0;
      to_cnt_q       <= '0;
      settle_q       <= '0;
      fid_rst_q      <= 1'b0;
      scan_flag_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      mask_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      to_cnt_q       <= to_cnt_d;
      settle_q       <= settle_d;
      fid_rst_q      <= (state_d == StClear);
      scan_flag_q    <= (state_d == StScan);
      busy_q         <= (state_d != StIdle);
      result_valid_q <= (state_d == StDone);
      if (latch) begin
        err_q   <= latch_err;
        mask_q  <= latch_mask;
        count_q <= finger_popcount(latch_mask);
      end
    end
  end

  // Write enable must line up with the pixel, so it is gated, not registered.
  assign capture_en   = pix_valid && (state_q == StCapture);
  assign fid_rst      = fid_rst_q;
  assign scan_flag    = scan_flag_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign finger_mask  = mask_q;
  assign finger_count = count_q;
  assign err_no_palm  = err_q;

endmodule

// File: tb/tb_gesture_frame_sequencer.sv
// Randomized frame-level bench for gesture_frame_sequencer with a timeline model.
module tb_gesture_frame_sequencer;

  localparam int unsigned W    = 16;
  localparam int unsigned H    = 8;
  localparam int unsigned TO   = 64;
  localparam int unsigned ST   = 4;
  localparam int          WH   = W * H;
  localparam int          MaxC = 2048;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic       palm_valid;
  logic [8:0] palm_width;
  logic [4:0] finger_status;
  logic       capture_en;
  logic       fid_rst;
  logic       scan_flag;
  logic [8:0] row_idx;
  logic [8:0] col_idx;
  logic       busy;
  logic       result_valid;
  logic       result_ready;
  logic [4:0] finger_mask;
  logic [2:0] finger_count;
  logic       err_no_palm;

  gesture_frame_sequencer #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .PALM_TIMEOUT (TO),
    .SETTLE_CYCLES(ST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pix_valid    (pix_valid),
    .palm_valid   (palm_valid),
    .palm_width   (palm_width),
    .finger_status(finger_status),
    .capture_en   (capture_en),
    .fid_rst      (fid_rst),
    .scan_flag    (scan_flag),
    .row_idx      (row_idx),
    .col_idx      (col_idx),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .finger_mask  (finger_mask),
    .finger_count (finger_count),
    .err_no_palm  (err_no_palm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cur_c = 0;
  logic chk_en = 1'b0;

  logic       e_cap, e_fid, e_scan, e_busy, e_rv, e_res, e_err;
  logic [8:0] e_row, e_col;
  logic [4:0] e_mask;
  logic [2:0] e_cnt;

  int obs_scan, obs_cap, obs_fid, obs_rv, obs_first_rv, obs_cnt, obs_err;
  logic [4:0] obs_mask;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur_c, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("capture_en", capture_en, e_cap);
      chk("fid_rst", fid_rst, e_fid);
      chk("scan_flag", scan_flag, e_scan);
      chk("row_idx", row_idx, e_row);
      chk("col_idx", col_idx, e_col);
      chk("busy", busy, e_busy);
      chk("result_valid", result_valid, e_rv);
      if (e_res) begin
        chk("finger_mask", finger_mask, e_mask);
        chk("finger_count", finger_count, e_cnt);
        chk("err_no_palm", err_no_palm, e_err);
      end
      if (scan_flag) obs_scan++;
      if (capture_en) obs_cap++;
      if (fid_rst) obs_fid++;
      if (result_valid) begin
        obs_rv++;
        if (obs_first_rv < 0) begin
          obs_first_rv = cur_c;
          obs_mask     = finger_mask;
          obs_cnt      = finger_count;
          obs_err      = err_no_palm;
        end
      end
    end
  end

  task automatic clear_obs();
    obs_scan = 0; obs_cap = 0; obs_fid = 0; obs_rv = 0;
    obs_first_rv = -1; obs_cnt = -1; obs_err = -1; obs_mask = '0;
  endtask

  task automatic run_idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_c = i; rst = r; start = 1'b0; pix_valid = 1'b0; palm_valid = 1'b0;
      palm_width = '0; finger_status = '0; result_ready = 1'b0;
      e_cap = 0; e_fid = 0; e_scan = 0; e_busy = 0; e_rv = 0; e_res = 1;
      e_err = 0; e_row = '0; e_col = '0; e_mask = '0; e_cnt = '0;
      chk_en = 1'b1;
    end
  endtask

  // Frame timeline relative to cycle 0, the cycle in which start is high.
  task automatic run_frame(input int gap_pct, input int palm_d, input logic [8:0] pw,
                           input logic [4:0] fs, input int ready_d, input bit start_noise,
                           input int rst_row);
    bit pv [0:MaxC-1];
    int ones, t_last, t_w, t_dec, t_scan, t_done, t_ack, t_end, rst_at;
    bit err, alive, in_scan;
    logic [4:0] mask;
    ones = 0; t_last = -1;
    for (int c = 0; c < MaxC; c++) begin
      pv[c] = ($urandom_range(0, 99) >= gap_pct);
      if (c >= 2 && t_last < 0 && pv[c]) begin
        ones++;
        if (ones == WH) t_last = c;
      end
    end
    t_w = t_last + 1;
    t_scan = -1;
    if (palm_d >= 0 && palm_d < TO) begin
      t_dec = t_w + palm_d;
      if (pw != 0) begin
        t_scan = t_dec + 1; t_done = t_scan + WH + ST; err = 0; mask = fs;
      end else begin
        t_done = t_dec + 1; err = 1; mask = '0;
      end
    end else begin
      t_dec = -1; t_done = t_w + TO; err = 1; mask = '0;
    end
    t_ack  = t_done + ready_d;
    rst_at = (rst_row >= 0 && t_scan >= 0) ? t_scan + rst_row * W + 5 : -1;
    t_end  = (rst_at >= 0) ? rst_at + 3 : t_ack + 3;
    clear_obs();
    for (int c = 0; c <= t_end; c++) begin
      @(posedge clk); #1;
      cur_c = c;
      alive = (rst_at < 0) || (c <= rst_at);
      rst = (c == rst_at);
      start = (c == 0) || (start_noise && c <= t_ack && $urandom_range(0, 3) == 0);
      pix_valid = pv[c];
      palm_valid = (c == t_dec);
      palm_width = (c == t_dec) ? pw : 9'($urandom_range(0, 511));
      finger_status = (c == t_done - 1) ? fs : 5'($urandom_range(0, 31));
      result_ready = (ready_d == 0) || (c >= t_ack);
      in_scan = alive && t_scan >= 0 && c >= t_scan && c < t_scan + WH;
      e_busy = alive && c >= 1 && c <= t_ack;
      e_fid  = alive && c == 1;
      e_cap  = alive && c >= 2 && c <= t_last && pv[c];
      e_scan = in_scan;
      e_row  = in_scan ? 9'((c - t_scan) / W) : 9'd0;
      e_col  = in_scan ? 9'((c - t_scan) % W) : 9'd0;
      e_rv   = alive && c >= t_done && c <= t_ack;
      e_res  = e_rv || !alive;
      e_mask = alive ? mask : 5'd0;
      e_cnt  = alive ? 3'($countones(mask)) : 3'd0;
      e_err  = alive ? err : 1'b0;
      chk_en = 1'b1;
    end
    @(posedge clk); #1;
    chk_en = 1'b0; rst = 1'b0; start = 1'b0; pix_valid = 1'b0; palm_valid = 1'b0;
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; palm_valid = 1'b0; palm_width = '0;
    finger_status = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    run_idle(3, 1'b1);
    run_idle(3, 1'b0);

    // Contiguous pixels, immediate palm and ready: 1+128+1+128+4+1 = 263.
    run_frame(0, 0, 9'd60, 5'b01110, 0, 1'b0, -1);
    chk("lat_first_rv", obs_first_rv, 263);
    chk("scan_cycles", obs_scan, 128);
    chk("cap_pixels", obs_cap, 128);
    chk("fid_pulses", obs_fid, 1);
    chk("mask_01110", obs_mask, 5'b01110);
    chk("count_01110", obs_cnt, 3);

    // Gappy pixel stream.
    run_frame(40, 3, 9'd100, 5'b10101, 2, 1'b0, -1);
    chk("gap_cap_pixels", obs_cap, 128);

    // Palm found with zero width.
    run_frame(10, 5, 9'd0, 5'b11111, 1, 1'b0, -1);
    chk("w0_scan", obs_scan, 0);
    chk("w0_err", obs_err, 1);
    chk("w0_mask", obs_mask, 0);

    // No palm at all: timeout, result at 1+128+64+1 = 194.
    run_frame(0, -1, 9'd0, 5'b11111, 0, 1'b0, -1);
    chk("to_first_rv", obs_first_rv, 194);
    chk("to_err", obs_err, 1);

    // Palm reported in the timeout cycle wins.
    run_frame(20, TO - 1, 9'd77, 5'b00011, 0, 1'b0, -1);
    chk("palm_wins_scan", obs_scan, 128);

    // Ready held off 100 cycles with start noise.
    run_frame(15, 2, 9'd33, 5'b11010, 100, 1'b1, -1);
    chk("hold_rv_cycles", obs_rv, 101);

    // Reset at row 3, col 5 of the scan, then a clean frame.
    run_frame(0, 0, 9'd60, 5'b01110, 0, 1'b0, 3);
    chk("rst_scan_cycles", obs_scan, 3 * 16 + 5 + 1);
    run_frame(25, 1, 9'd61, 5'b11111, 0, 1'b0, -1);
    chk("post_rst_count", obs_cnt, 5);

    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(0, 50),
                ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20)),
                ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511)),
                5'($urandom_range(0, 31)), $urandom_range(0, 6),
                1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
